spi_frame_loader: RTL and testbench

Parametrised SPI slave that loads display frame memory from an external host and reads it back. It sits between the `spi_*` pins of `top` and a single-port frame RAM, and supports all four SPI modes and configurable word width and memory depth. Each transaction is framed by `spi_ss` low: one command byte, then auto-incrementing data words. Memory reads are prefetched so read data shifts out on `spi_miso`.

---
 rtl/spi_frame_loader.sv | 193 +++++++++++++++++++
 tb/tb_spi_frame_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_loader.sv
// spi_frame_loader
//   SPI slave that streams words between an external host and a single-port
//   frame RAM. A frame is bounded by spi_ss low. The first byte is a command:
//   0xF0 writes, 0xF8 reads, and anything else makes the slave ignore the
//   rest of the frame. After the command, data words auto-increment the
//   address pointer from 0. Read data is prefetched one word ahead.
//
// Ports
//   clk, rst             system clock; asynchronous active-high reset
//   spi_sclk/ss/mosi     raw SPI pins (asynchronous to clk)
//   spi_miso             registered serial read data, MSB first
//   mem_addr/wdata       RAM address and write data
//   mem_we, mem_re       one-cycle write and read strobes
//   mem_rdata            RAM read data, valid the cycle after mem_re
//   busy                 frame in progress
//   frame_done           pulse at the end of a write frame that stored data
module spi_frame_loader #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 10,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  spi_sclk,
   input  logic                  spi_ss,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   output logic                  mem_re,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int   CW          = $clog2(DATA_WIDTH + 1);
   localparam logic CPOL_L      = (CPOL != 0);
   localparam logic SAMPLE_FALL = (CPOL != 0) ^ (CPHA != 0);

   typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, IGNORE} state_t;

   state_t                  state;
   logic [SYNC_STAGES-1:0]  sclk_sync, ss_sync, mosi_sync;
   logic                    sclk_hist, ss_hist;
   logic                    armed;
   logic [CW-1:0]           cnt;
   logic [DATA_WIDTH-1:0]   rx, tx;
   logic [ADDR_WIDTH-1:0]   ptr;
   logic                    wrote;
   logic                    re_pend;

   logic                    sclk_s, ss_s, mosi_s;
   logic                    sclk_rise, sclk_fall, ss_rise, ss_fall;
   logic                    sample_edge, shift_edge;
   logic [DATA_WIDTH-1:0]   word_in;
   logic                    word_last, cmd_last;

   assign sclk_s      = sclk_sync[SYNC_STAGES-1];
   assign ss_s        = ss_sync[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise   = sclk_s & ~sclk_hist;
   assign sclk_fall   = ~sclk_s & sclk_hist;
   assign ss_rise     = ss_s & ~ss_hist;
   assign ss_fall     = ~ss_s & ss_hist;
   assign sample_edge = SAMPLE_FALL ? sclk_fall : sclk_rise;
   assign shift_edge  = SAMPLE_FALL ? sclk_rise : sclk_fall;
   assign word_in     = {rx[DATA_WIDTH-2:0], mosi_s};
   assign word_last   = (cnt == CW'(DATA_WIDTH - 1));
   assign cmd_last    = (cnt == CW'(7));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync  <= {SYNC_STAGES{CPOL_L}};
         // ss resets low so a frame already running at reset release shows
         // no falling edge; armed then keeps IDLE deaf until ss has been high.
         ss_sync    <= '0;
         mosi_sync  <= '0;
         sclk_hist  <= CPOL_L;
         ss_hist    <= 1'b0;
         armed      <= 1'b0;
         state      <= IDLE;
         cnt        <= '0;
         rx         <= '0;
         tx         <= '0;
         ptr        <= '0;
         wrote      <= 1'b0;
         re_pend    <= 1'b0;
         spi_miso   <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
         mem_re     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         ss_sync    <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
         mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         sclk_hist  <= sclk_s;
         ss_hist    <= ss_s;
         if (ss_s) armed <= 1'b1;
         mem_we     <= 1'b0;
         mem_re     <= 1'b0;
         frame_done <= 1'b0;
         re_pend    <= mem_re;

         // ss rise wins over any sample edge in the same cycle; a partial
         // word is simply dropped.
         if (state != IDLE && ss_rise) begin
            state      <= IDLE;
            busy       <= 1'b0;
            spi_miso   <= 1'b0;
            cnt        <= '0;
            frame_done <= (state == WRITE) && wrote;
            wrote      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (ss_fall && armed) begin
                     state <= CMD;
                     cnt   <= '0;
                     busy  <= 1'b1;
                  end
               end
               CMD: begin
                  if (sample_edge) begin
                     rx  <= word_in;
                     cnt <= cnt + 1'b1;
                     if (cmd_last) begin
                        cnt <= '0;
                        ptr <= '0;
                        case (word_in[7:0])
                           8'hF0: state <= WRITE;
                           8'hF8: begin
                              state    <= READ;
                              mem_re   <= 1'b1;
                              mem_addr <= '0;
                           end
                           default: state <= IGNORE;
                        endcase
                     end
                  end
               end
               WRITE: begin
                  if (sample_edge) begin
                     rx  <= word_in;
                     cnt <= cnt + 1'b1;
                     if (word_last) begin
                        cnt       <= '0;
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= word_in;
                        ptr       <= ptr + 1'b1;
                        wrote     <= 1'b1;
                     end
                  end
               end
               READ: begin
                  // tx holds the bits not yet on the pin. With CPHA=0 the
                  // MSB goes out at load time, so the trailing edge right
                  // after a word boundary (cnt==0) must not advance.
                  if (re_pend) begin
                     if (CPHA == 0) begin
                        spi_miso <= mem_rdata[DATA_WIDTH-1];
                        tx       <= {mem_rdata[DATA_WIDTH-2:0], 1'b0};
                     end else begin
                        tx       <= mem_rdata;
                     end
                  end else if (shift_edge && (CPHA != 0 || cnt != '0)) begin
                     spi_miso <= tx[DATA_WIDTH-1];
                     tx       <= {tx[DATA_WIDTH-2:0], 1'b0};
                  end
                  if (sample_edge) begin
                     cnt <= cnt + 1'b1;
                     if (word_last) begin
                        cnt      <= '0;
                        ptr      <= ptr + 1'b1;
                        mem_addr <= ptr + 1'b1;
                        mem_re   <= 1'b1;
                     end
                  end
               end
               IGNORE: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed bench for spi_frame_loader: four instances (mode 0 8/10, mode 0
// with a 4-word RAM, mode 3 and mode 1 with 16-bit words), each with a small
// RAM model and strobe logs. A bit-banged host drives one instance at a time.
module tb_spi_frame_loader;

   localparam int PH = 8;   // clk cycles per SCLK phase

   logic        clk = 1'b0;
   logic        rst;
   logic        base, mosi;
   logic [3:0]  ss;
   logic [3:0]  miso, we, re, busy, fd;
   logic [9:0]  a0, a2, a3;
   logic [1:0]  a1;
   logic [7:0]  wd0, wd1;
   logic [15:0] wd2, wd3;
   logic [7:0]  rd0 = '0, rd1 = '0;
   logic [15:0] rd2 = '0, rd3 = '0;
   logic [7:0]  m0 [1024];
   logic [7:0]  m1 [4];
   logic [15:0] m2 [1024];
   logic [15:0] m3 [1024];
   logic [3:0][15:0] ax, wdx;

   logic [15:0] wa [4][64];
   logic [15:0] wv [4][64];
   logic [15:0] ra [4][64];
   int          wn [4] = '{0, 0, 0, 0};
   int          rn [4] = '{0, 0, 0, 0};
   int          fn [4] = '{0, 0, 0, 0};

   int          checks = 0, failures = 0;
   int          sel;
   logic        cpha;
   int          bw, br, bf;
   logic [31:0] r, r1, r2, r3;

   always #5 clk = ~clk;

   spi_frame_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .CPOL(0), .CPHA(0)) u0 (
      .clk(clk), .rst(rst), .spi_sclk(base), .spi_ss(ss[0]), .spi_mosi(mosi),
      .spi_miso(miso[0]), .mem_addr(a0), .mem_wdata(wd0), .mem_we(we[0]),
      .mem_re(re[0]), .mem_rdata(rd0), .busy(busy[0]), .frame_done(fd[0]));
   spi_frame_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .CPOL(0), .CPHA(0)) u1 (
      .clk(clk), .rst(rst), .spi_sclk(base), .spi_ss(ss[1]), .spi_mosi(mosi),
      .spi_miso(miso[1]), .mem_addr(a1), .mem_wdata(wd1), .mem_we(we[1]),
      .mem_re(re[1]), .mem_rdata(rd1), .busy(busy[1]), .frame_done(fd[1]));
   spi_frame_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .CPOL(1), .CPHA(1)) u2 (
      .clk(clk), .rst(rst), .spi_sclk(~base), .spi_ss(ss[2]), .spi_mosi(mosi),
      .spi_miso(miso[2]), .mem_addr(a2), .mem_wdata(wd2), .mem_we(we[2]),
      .mem_re(re[2]), .mem_rdata(rd2), .busy(busy[2]), .frame_done(fd[2]));
   spi_frame_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .CPOL(0), .CPHA(1)) u3 (
      .clk(clk), .rst(rst), .spi_sclk(base), .spi_ss(ss[3]), .spi_mosi(mosi),
      .spi_miso(miso[3]), .mem_addr(a3), .mem_wdata(wd3), .mem_we(we[3]),
      .mem_re(re[3]), .mem_rdata(rd3), .busy(busy[3]), .frame_done(fd[3]));

   assign ax[0]  = 16'(a0);
   assign ax[1]  = 16'(a1);
   assign ax[2]  = 16'(a2);
   assign ax[3]  = 16'(a3);
   assign wdx[0] = 16'(wd0);
   assign wdx[1] = 16'(wd1);
   assign wdx[2] = wd2;
   assign wdx[3] = wd3;

   // RAM models
   always @(posedge clk) begin
      if (we[0]) m0[a0] <= wd0;
      if (re[0]) rd0 <= m0[a0];
      if (we[1]) m1[a1] <= wd1;
      if (re[1]) rd1 <= m1[a1];
      if (we[2]) m2[a2] <= wd2;
      if (re[2]) rd2 <= m2[a2];
      if (we[3]) m3[a3] <= wd3;
      if (re[3]) rd3 <= m3[a3];
   end

   // strobe logs
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (we[k]) begin
            wa[k][wn[k] % 64] <= ax[k];
            wv[k][wn[k] % 64] <= wdx[k];
            wn[k] <= wn[k] + 1;
         end
         if (re[k]) begin
            ra[k][rn[k] % 64] <= ax[k];
            rn[k] <= rn[k] + 1;
         end
         if (fd[k]) fn[k] <= fn[k] + 1;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic snap(input int k);
      bw = wn[k];
      br = rn[k];
      bf = fn[k];
   endtask

   task automatic start(input int s);
      sel  = s;
      cpha = (s >= 2);
      snap(s);
      ss[s] = 1'b0;
      cyc(PH);
   endtask

   task automatic stop();
      cyc(PH);
      ss[sel] = 1'b1;
      cyc(PH + 4);
   endtask

   // Shift nb bits of d out MSB first, collecting miso at each sample edge.
   task automatic xfer(input int nb, input logic [31:0] d, output logic [31:0] q);
      q = '0;
      for (int i = nb - 1; i >= 0; i--) begin
         if (!cpha) begin
            mosi = d[i];
            cyc(PH);
            q = {q[30:0], miso[sel]};
            base = 1'b1;
            cyc(PH);
            base = 1'b0;
         end else begin
            base = 1'b1;
            mosi = d[i];
            cyc(PH);
            q = {q[30:0], miso[sel]};
            base = 1'b0;
            cyc(PH);
         end
      end
   endtask

   task automatic chk_zero0(input string tag);
      chk({tag, "_miso"},  32'(miso[0]), 0);
      chk({tag, "_we"},    32'(we[0]),   0);
      chk({tag, "_re"},    32'(re[0]),   0);
      chk({tag, "_busy"},  32'(busy[0]), 0);
      chk({tag, "_fd"},    32'(fd[0]),   0);
      chk({tag, "_addr"},  32'(a0),      0);
      chk({tag, "_wdata"}, 32'(wd0),     0);
   endtask

   initial begin
      rst = 1'b1; ss = '1; base = 1'b0; mosi = 1'b0; sel = 0; cpha = 1'b0;
      cyc(3);
      chk_zero0("reset");
      rst = 1'b0;
      cyc(10);

      // write F0 AA 55
      start(0);
      xfer(8, 'hF0, r);
      xfer(8, 'hAA, r);
      chk("wr_busy_mid", 32'(busy[0]), 1);
      xfer(8, 'h55, r);
      stop();
      chk("wr_we_n",  wn[0] - bw, 2);
      chk("wr_a0",    32'(wa[0][bw % 64]), 0);
      chk("wr_d0",    32'(wv[0][bw % 64]), 'hAA);
      chk("wr_a1",    32'(wa[0][(bw + 1) % 64]), 1);
      chk("wr_d1",    32'(wv[0][(bw + 1) % 64]), 'h55);
      chk("wr_fd_n",  fn[0] - bf, 1);
      chk("wr_busy_end", 32'(busy[0]), 0);

      // read back two words
      start(0);
      xfer(8, 'hF8, r);
      xfer(8, 'h00, r1);
      xfer(8, 'h00, r2);
      stop();
      chk("rd_w0",   r1, 'hAA);
      chk("rd_w1",   r2, 'h55);
      chk("rd_re_n", rn[0] - br, 3);
      chk("rd_a0",   32'(ra[0][br % 64]), 0);
      chk("rd_a1",   32'(ra[0][(br + 1) % 64]), 1);
      chk("rd_a2",   32'(ra[0][(br + 2) % 64]), 2);
      chk("rd_fd_n", fn[0] - bf, 0);
      chk("rd_miso_idle", 32'(miso[0]), 0);

      // 4-word RAM: address wrap
      start(1);
      xfer(8, 'hF0, r);
      for (int i = 1; i <= 5; i++) xfer(8, 32'(i), r);
      stop();
      chk("wrap_we_n", wn[1] - bw, 5);
      chk("wrap_a0", 32'(wa[1][bw % 64]), 0);
      chk("wrap_a1", 32'(wa[1][(bw + 1) % 64]), 1);
      chk("wrap_a2", 32'(wa[1][(bw + 2) % 64]), 2);
      chk("wrap_a3", 32'(wa[1][(bw + 3) % 64]), 3);
      chk("wrap_a4", 32'(wa[1][(bw + 4) % 64]), 0);
      chk("wrap_mem0", 32'(m1[0]), 5);
      start(1);
      xfer(8, 'hF8, r);
      xfer(8, 'h00, r1);
      stop();
      chk("wrap_rd0", r1, 5);

      // unknown command is ignored
      start(0);
      xfer(8, 'h3C, r1);
      xfer(8, 'h11, r2);
      xfer(8, 'h22, r3);
      stop();
      chk("ign_we_n",  wn[0] - bw, 0);
      chk("ign_re_n",  rn[0] - br, 0);
      chk("ign_miso",  r2 | r3, 0);
      chk("ign_fd_n",  fn[0] - bf, 0);

      // ss raised 5 bits into the second word
      start(0);
      xfer(8, 'hF0, r);
      xfer(8, 'hA1, r);
      xfer(5, 'h1F, r);
      stop();
      chk("part_we_n", wn[0] - bw, 1);
      chk("part_a",    32'(wa[0][bw % 64]), 0);
      chk("part_d",    32'(wv[0][bw % 64]), 'hA1);
      chk("part_fd_n", fn[0] - bf, 1);

      // mode 3 and mode 1, 16-bit words
      for (int s = 2; s <= 3; s++) begin
         start(s);
         xfer(8, 'hF0, r);
         xfer(16, 'hBEEF, r);
         stop();
         chk("m16_we_n", wn[s] - bw, 1);
         chk("m16_a",    32'(wa[s][bw % 64]), 0);
         chk("m16_d",    32'(wv[s][bw % 64]), 'hBEEF);
         chk("m16_fd_n", fn[s] - bf, 1);
         start(s);
         xfer(8, 'hF8, r);
         xfer(16, 'h0000, r1);
         stop();
         chk("m16_rd", r1, 'hBEEF);
      end

      // reset mid-word of a write frame
      start(0);
      xfer(8, 'hF0, r);
      xfer(4, 'hA, r);
      rst = 1'b1;
      #1;
      chk_zero0("midrst");
      cyc(3);
      rst = 1'b0;
      cyc(PH);
      xfer(4, 'h5, r);
      xfer(8, 'h99, r);
      stop();
      chk("midrst_we_n", wn[0] - bw, 0);
      chk("midrst_fd_n", fn[0] - bf, 0);
      start(0);
      xfer(8, 'hF0, r);
      xfer(8, 'h77, r);
      stop();
      chk("post_we_n", wn[0] - bw, 1);
      chk("post_a",    32'(wa[0][bw % 64]), 0);
      chk("post_d",    32'(wv[0][bw % 64]), 'h77);
      chk("post_fd_n", fn[0] - bf, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
